// File: rtl/data_port_arbiter.sv
// Data memory port arbiter: execute stage (req 0) and debug/loader (req 1)
// share one single-port data memory with round-robin grant and a halt gate.
//
// Ports:
//   i_clock, i_reset_n        clock (rising edge), async active-low reset
//   i_halt                    blocks new execute grants
//   i_ex_*  / o_ex_*          execute req/we/addr/wdata, ack/rdata
//   i_dbg_* / o_dbg_*         debug req/we/addr/wdata, ack/rdata
//   o_mem_* / i_mem_rdata     registered memory strobe, we, addr, wdata
//   o_busy                    high while an access is in flight
module data_port_arbiter #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_halt,
    input  logic              i_ex_req,
    input  logic              i_ex_we,
    input  logic [ADDR_W-1:0] i_ex_addr,
    input  logic [DATA_W-1:0] i_ex_wdata,
    output logic              o_ex_ack,
    output logic [DATA_W-1:0] o_ex_rdata,
    input  logic              i_dbg_req,
    input  logic              i_dbg_we,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    input  logic [DATA_W-1:0] i_dbg_wdata,
    output logic              o_dbg_ack,
    output logic [DATA_W-1:0] o_dbg_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    localparam int LAT_W = 3;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LATENCY - 1);

    logic [1:0]       r_state;
    logic [LAT_W-1:0] r_lat_cnt;
    // 0 = execute, 1 = debug
    logic             r_ptr;
    logic             r_owner;

    logic w_ex_elig;
    logic w_dbg_elig;
    logic w_any;
    logic w_pick_dbg;

    assign w_ex_elig  = i_ex_req & ~i_halt;
    assign w_dbg_elig = i_dbg_req;
    assign w_any      = w_ex_elig | w_dbg_elig;
    // Debug wins when it is alone or when the pointer names it.
    assign w_pick_dbg = w_dbg_elig & (~w_ex_elig | r_ptr);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_lat_cnt   <= '0;
            r_ptr       <= 1'b0;
            r_owner     <= 1'b0;
            o_ex_ack    <= 1'b0;
            o_ex_rdata  <= '0;
            o_dbg_ack   <= 1'b0;
            o_dbg_rdata <= '0;
            o_mem_en    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_busy      <= 1'b0;
        end else begin
            o_ex_ack  <= 1'b0;
            o_dbg_ack <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner     <= w_pick_dbg;
                        r_ptr       <= ~w_pick_dbg;
                        o_mem_en    <= 1'b1;
                        o_mem_we    <= w_pick_dbg ? i_dbg_we : i_ex_we;
                        o_mem_addr  <= w_pick_dbg ? i_dbg_addr : i_ex_addr;
                        o_mem_wdata <= w_pick_dbg ? i_dbg_wdata : i_ex_wdata;
                        o_busy      <= 1'b1;
                        r_state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    o_mem_en <= 1'b0;
                    o_mem_we <= 1'b0;
                    // o_mem_we still reflects the access being issued.
                    if (o_mem_we) begin
                        o_ex_ack  <= ~r_owner;
                        o_dbg_ack <= r_owner;
                        o_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_lat_cnt <= LAT_INIT;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_lat_cnt != '0) begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                    end else begin
                        if (r_owner) begin
                            o_dbg_rdata <= i_mem_rdata;
                            o_dbg_ack   <= 1'b1;
                        end else begin
                            o_ex_rdata <= i_mem_rdata;
                            o_ex_ack   <= 1'b1;
                        end
                        o_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    o_mem_en <= 1'b0;
                    o_mem_we <= 1'b0;
                    o_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/data_port_arbiter.md
Name: data_port_arbiter

Overview:
- Shares the single-port 32-bit data memory between two requesters: the execute stage (req 0) and the debug/loader port (req 1).
- Uses a req/ack handshake per requester, round-robin arbitration and a halt gate.
- Issues one registered access at a time and returns read data with the ack.
- Sits between the execute stage, the debug unit and the data memory.

Parameters:
ADDR_W, 9, address width (matches data memory index width)
DATA_W, 32, data width
RD_LATENCY, 1, memory read latency in cycles (1..4), counted from the cycle mem_en is high

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
halt  in  1  core stopped (breakpoint); blocks new execute grants
ex_req  in  1  execute request, held until ex_ack
ex_we  in  1  1=write 0=read, stable while ex_req
ex_addr  in  ADDR_W  execute address, stable while ex_req
ex_wdata  in  DATA_W  execute write data, stable while ex_req
ex_ack  out  1  one-cycle completion pulse
ex_rdata  out  DATA_W  read data, valid in ex_ack cycle, held until next execute read completes
dbg_req  in  1  debug request, same rules as ex_req
dbg_we  in  1  debug write enable
dbg_addr  in  ADDR_W  debug address
dbg_wdata  in  DATA_W  debug write data
dbg_ack  out  1  one-cycle completion pulse
dbg_rdata  out  DATA_W  debug read data, same rules as ex_rdata
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  state != IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0; state IDLE; lat_cnt 0.
  - Priority pointer = execute; grant owner cleared.
  - Any in-flight access is abandoned with no ack.
- All outputs are registered.
- States: IDLE, ACCESS, WAIT_RD.
- IDLE:
  - Eligible requesters: ex_req & ~halt, and dbg_req.
  - None eligible -> stay in IDLE; mem_en=0.
  - One eligible -> grant it.
  - Both eligible -> grant the requester named by the priority pointer.
  - On grant (edge k): latch owner; drive mem_en=1, mem_we, mem_addr, mem_wdata from the owner; go to ACCESS; pointer <= the other requester.
- ACCESS (one cycle; mem_en high in this cycle):
  - Write: at edge k+1 mem_en=0, mem_we=0, owner ack=1, -> IDLE.
  - Read: at edge k+1 mem_en=0, lat_cnt <= RD_LATENCY-1, -> WAIT_RD.
  - If RD_LATENCY=1, capture mem_rdata at edge k+2 instead (WAIT_RD with lat_cnt=0).
- WAIT_RD:
  - lat_cnt != 0 -> decrement.
  - lat_cnt == 0 -> owner rdata <= mem_rdata, owner ack=1, -> IDLE.
- Latency, req sampled at edge k:
  - Write ack high in the cycle after edge k+1.
  - Read ack high in the cycle after edge k+1+RD_LATENCY.
  - Next grant no earlier than the edge on which ack rises, i.e. ack cycle = IDLE cycle.
- The requester must deassert req in the ack cycle, or present a new request.
  - A request still high in the ack cycle is treated as a new request and is re-arbitrated.
- ack is a one-cycle pulse; the other requester's ack never fires in the same cycle.
- halt:
  - Rising while an execute access is in flight: the access completes and is acked normally.
  - While high: ex_req is ignored for grant; debug is served back-to-back.
  - Pointer is not updated by blocked requests.
- Request dropped before ack (protocol violation): the access still completes and the ack is still pulsed; rdata is updated.
- mem_addr, mem_wdata and mem_we hold their last values when mem_en=0, except mem_we, which is cleared.
- No address wrap logic; addresses pass through unchanged. Data is not modified (no byte lanes).
- busy = 1 in ACCESS and WAIT_RD.

Test Plan:
- Execute write then read, RD_LATENCY=1:
  - Write ex_addr=0x012, ex_wdata=0xDEADBEEF -> mem_en=1, mem_we=1, mem_addr=0x012 for one cycle; ex_ack pulses 2 cycles after req.
  - Read 0x012 (memory returns 0xDEADBEEF) -> ex_ack 3 cycles after req with ex_rdata=0xDEADBEEF; dbg_ack stays 0.
- Contention after reset:
  - ex_req and dbg_req both high, both reads -> execute granted first, debug second.
  - Sustained contention -> grants alternate ex, dbg, ex, dbg; each ack precedes the next grant's mem_en.
- halt:
  - halt=1 with ex_req and dbg_req high -> only debug is granted; ex_ack=0 while halt=1.
  - Drop halt -> execute is granted in the next IDLE cycle.
- halt mid-access: set halt=1 while an execute read is in WAIT_RD -> ex_ack still pulses with correct data.
- RD_LATENCY=3: debug read at addr 0x1FF returns 0x00000055 -> dbg_ack 5 cycles after req; dbg_rdata=0x00000055; busy high for 4 cycles.
- Reset during WAIT_RD: reset=0 -> mem_en, acks and busy go 0 immediately; after release no ack for the abandoned access; next simultaneous request goes to execute.
